// File: rtl/pattern_stream_sched.sv
// Round-robin front end for two byte requesters feeding a bit-serial Moore
// pattern detector; reports per-byte overlapping match count and owner id.
module pattern_stream_sched #(
    parameter int unsigned        DATA_W  = 8,
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              inbit,
    output logic              ans,
    output logic              busy,
    output logic              done,
    output logic              done_id,
    output logic [3:0]        done_count
);

    localparam int unsigned BIT_W  = $clog2(DATA_W);
    localparam int unsigned SEEN_W = $clog2(PAT_LEN + 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [SEEN_W-1:0] SEEN_FULL = SEEN_W'(PAT_LEN);
    localparam logic [3:0]        CNT_MAX   = 4'(DATA_W - PAT_LEN + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   shreg;
    logic [BIT_W-1:0]    bitcnt;
    logic [PAT_LEN-1:0]  hist;
    logic [SEEN_W-1:0]   seen;
    logic [3:0]          mcount, cnt_nxt;
    logic                cur_id;
    logic                last_grant;
    logic                grant;
    logic                accept;
    logic                match;

    assign match = (hist == PATTERN) && (seen >= SEEN_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        inbit      = 1'b0;
        ans        = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        cnt_nxt    = mcount;

        if (req0_valid && req1_valid) grant = ~last_grant;
        else                          grant = req1_valid;

        case (state)
            IDLE: begin
                // rst_n gating keeps ready low while reset is held with valid up
                req0_ready = rst_n & ~grant & req0_valid;
                req1_ready = rst_n &  grant & req1_valid;
                accept     = req0_ready | req1_ready;
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                inbit = shreg[DATA_W-1];
                ans   = match;
                if (bitcnt == LAST_BIT) state_nxt = FLUSH;
            end
            FLUSH: begin
                ans       = match;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (ans && (mcount != CNT_MAX)) cnt_nxt = mcount + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            bitcnt     <= '0;
            hist       <= '0;
            seen       <= '0;
            mcount     <= '0;
            cur_id     <= 1'b0;
            last_grant <= 1'b1;
            done_id    <= 1'b0;
            done_count <= '0;
        end else begin
            mcount <= cnt_nxt;
            if (accept) begin
                shreg      <= grant ? req1_data : req0_data;
                cur_id     <= grant;
                last_grant <= grant;
                bitcnt     <= '0;
                hist       <= '0;
                seen       <= '0;
                mcount     <= '0;
            end
            if (state == SHIFT) begin
                shreg  <= {shreg[DATA_W-2:0], 1'b0};
                bitcnt <= bitcnt + 1'b1;
                hist   <= {hist[PAT_LEN-2:0], inbit};
                if (seen != SEEN_FULL) seen <= seen + 1'b1;
            end
            // Result captured with the FLUSH-cycle match included, held until next DONE
            if (state == FLUSH) begin
                done_id    <= cur_id;
                done_count <= cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pattern_stream_sched.sv
// Directed bench for pattern_stream_sched: hand-computed inbit/ans/done
// timelines for arbitration, detection, flush, reset abort and ignored valids.
module tb_pattern_stream_sched;

    logic       clk;
    logic       rst_n;

    logic       a_req0_valid, a_req1_valid, a_req0_ready, a_req1_ready;
    logic [7:0] a_req0_data, a_req1_data;
    logic       a_inbit, a_ans, a_busy, a_done, a_done_id;
    logic [3:0] a_done_count;

    logic       b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic [7:0] b_req0_data, b_req1_data;
    logic       b_inbit, b_ans, b_busy, b_done, b_done_id;
    logic [3:0] b_done_count;

    int vectors;
    int miscompares;
    int unit_sel;

    logic       s_ready0, s_ready1, s_inbit, s_ans, s_busy, s_done, s_id;
    logic [3:0] s_cnt;

    pattern_stream_sched #(
        .DATA_W (8),
        .PAT_LEN(4),
        .PATTERN(4'b1011)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(a_req0_valid),
        .req0_data (a_req0_data),
        .req0_ready(a_req0_ready),
        .req1_valid(a_req1_valid),
        .req1_data (a_req1_data),
        .req1_ready(a_req1_ready),
        .inbit     (a_inbit),
        .ans       (a_ans),
        .busy      (a_busy),
        .done      (a_done),
        .done_id   (a_done_id),
        .done_count(a_done_count)
    );

    pattern_stream_sched #(
        .DATA_W (8),
        .PAT_LEN(4),
        .PATTERN(4'b1111)
    ) dut_ones (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(b_req0_valid),
        .req0_data (b_req0_data),
        .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid),
        .req1_data (b_req1_data),
        .req1_ready(b_req1_ready),
        .inbit     (b_inbit),
        .ans       (b_ans),
        .busy      (b_busy),
        .done      (b_done),
        .done_id   (b_done_id),
        .done_count(b_done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (unit_sel == 0) begin
            s_ready0 = a_req0_ready; s_ready1 = a_req1_ready;
            s_inbit  = a_inbit;      s_ans    = a_ans;
            s_busy   = a_busy;       s_done   = a_done;
            s_id     = a_done_id;    s_cnt    = a_done_count;
        end else begin
            s_ready0 = b_req0_ready; s_ready1 = b_req1_ready;
            s_inbit  = b_inbit;      s_ans    = b_ans;
            s_busy   = b_busy;       s_done   = b_done;
            s_id     = b_done_id;    s_cnt    = b_done_count;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_inputs(input int unit, input logic v0, input logic [7:0] d0,
                              input logic v1, input logic [7:0] d1);
        if (unit == 0) begin
            a_req0_valid = v0; a_req0_data = d0; a_req1_valid = v1; a_req1_data = d1;
        end else begin
            b_req0_valid = v0; b_req0_data = d0; b_req1_valid = v1; b_req1_data = d1;
        end
    endtask

    // One job from its IDLE handshake cycle T through T+11.
    // Masks are cycles T+1..T+10, leftmost bit = T+1.
    task automatic job(input string tag, input int unit,
                       input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1,
                       input logic hold, input logic exp_id,
                       input logic [9:0] exp_ans, input logic [3:0] exp_cnt);
        logic [9:0] am, im, bm, dm, rm;
        logic [7:0] gdata;
        am = '0; im = '0; bm = '0; dm = '0; rm = '0;
        gdata = exp_id ? d1 : d0;
        unit_sel = unit;
        set_inputs(unit, v0, d0, v1, d1);
        #1;
        check({tag, "_ready0"}, 32'(s_ready0), 32'(v0 & ~exp_id));
        check({tag, "_ready1"}, 32'(s_ready1), 32'(v1 & exp_id));
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 1 && !hold) set_inputs(unit, 1'b0, d0, 1'b0, d1);
            #1;
            am[10-i] = s_ans;
            im[10-i] = s_inbit;
            bm[10-i] = s_busy;
            dm[10-i] = s_done;
            rm[10-i] = s_ready0 | s_ready1;
        end
        check({tag, "_inbit"}, 32'(im), 32'({gdata, 2'b00}));
        check({tag, "_ans"},   32'(am), 32'(exp_ans));
        check({tag, "_busy"},  32'(bm), 32'(10'b1111111111));
        check({tag, "_done"},  32'(dm), 32'(10'b0000000001));
        check({tag, "_rdy_busy"}, 32'(rm), 32'(0));
        check({tag, "_id"},    32'(s_id),  32'(exp_id));
        check({tag, "_count"}, 32'(s_cnt), 32'(exp_cnt));
        @(posedge clk);
        #2;
        check({tag, "_idle_busy"}, 32'(s_busy), 32'(0));
        check({tag, "_idle_done"}, 32'(s_done), 32'(0));
        check({tag, "_held_id"},   32'(s_id),   32'(exp_id));
        check({tag, "_held_cnt"},  32'(s_cnt),  32'(exp_cnt));
    endtask

    initial begin
        logic [9:0] rmask, dmask;
        int         late_done, late_rdy;
        vectors = 0;
        miscompares = 0;
        unit_sel = 0;
        rst_n = 1'b0;
        set_inputs(0, 1'b1, 8'hB6, 1'b1, 8'hBB);
        set_inputs(1, 1'b0, 8'h00, 1'b0, 8'h00);

        // Power-on reset with both valids up
        #12;
        check("rst_ready0", 32'(a_req0_ready), 32'(0));
        check("rst_ready1", 32'(a_req1_ready), 32'(0));
        check("rst_inbit",  32'(a_inbit), 32'(0));
        check("rst_ans",    32'(a_ans),   32'(0));
        check("rst_busy",   32'(a_busy),  32'(0));
        check("rst_done",   32'(a_done),  32'(0));
        check("rst_id",     32'(a_done_id), 32'(0));
        check("rst_count",  32'(a_done_count), 32'(0));
        check("rst_b_busy", 32'(b_busy), 32'(0));
        set_inputs(0, 1'b0, 8'h00, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        job("b6",  0, 1'b1, 8'hB6, 1'b0, 8'h00, 1'b0, 1'b0, 10'b0000100100, 4'd2);
        job("x01", 0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 10'b0000000000, 4'd0);
        job("x60", 0, 1'b1, 8'h60, 1'b0, 8'h00, 1'b0, 1'b0, 10'b0000000000, 4'd0);
        job("x5b", 0, 1'b0, 8'h00, 1'b1, 8'h5B, 1'b0, 1'b1, 10'b0000010010, 4'd2);
        job("xb5", 0, 1'b0, 8'h00, 1'b1, 8'hB5, 1'b0, 1'b1, 10'b0000100000, 4'd1);

        // Mid-job reset at T+4; last_grant was 0 before it
        unit_sel = 0;
        a_req0_valid = 1'b1; a_req0_data = 8'hFF;
        #1;
        check("abort_ready", 32'(a_req0_ready), 32'(1));
        @(posedge clk);
        #1;
        a_req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_t4",  32'(a_busy),  32'(1));
        check("abort_inbit_t4", 32'(a_inbit), 32'(1));
        set_inputs(0, 1'b1, 8'h00, 1'b1, 8'hBB);
        rst_n = 1'b0;
        #1;
        check("abort_ready0", 32'(a_req0_ready), 32'(0));
        check("abort_ready1", 32'(a_req1_ready), 32'(0));
        check("abort_inbit",  32'(a_inbit), 32'(0));
        check("abort_ans",    32'(a_ans),   32'(0));
        check("abort_busy",   32'(a_busy),  32'(0));
        check("abort_done",   32'(a_done),  32'(0));
        check("abort_id",     32'(a_done_id), 32'(0));
        check("abort_count",  32'(a_done_count), 32'(0));
        repeat (2) begin
            @(posedge clk);
            #1;
            check("abort_hold_done", 32'(a_done), 32'(0));
        end
        rst_n = 1'b1;

        // Tie after reset: req0 first, then strict alternation while both held
        job("tie0", 0, 1'b1, 8'h00, 1'b1, 8'hBB, 1'b1, 1'b0, 10'b0000000000, 4'd0);
        job("alt1", 0, 1'b1, 8'h00, 1'b1, 8'hBB, 1'b1, 1'b1, 10'b0000100010, 4'd2);
        job("alt2", 0, 1'b1, 8'h00, 1'b1, 8'hBB, 1'b1, 1'b0, 10'b0000000000, 4'd0);
        job("alt3", 0, 1'b1, 8'h00, 1'b1, 8'hBB, 1'b0, 1'b1, 10'b0000100010, 4'd2);

        // req0 valid pulsed only during SHIFT must never be accepted
        unit_sel = 0;
        a_req1_valid = 1'b1; a_req1_data = 8'h5B;
        #1;
        check("pulse_ready1", 32'(a_req1_ready), 32'(1));
        check("pulse_ready0", 32'(a_req0_ready), 32'(0));
        rmask = '0; dmask = '0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) a_req1_valid = 1'b0;
            if (i == 2) begin a_req0_valid = 1'b1; a_req0_data = 8'hFF; end
            if (i == 6) a_req0_valid = 1'b0;
            #1;
            rmask[10-i] = a_req0_ready;
            dmask[10-i] = a_done;
        end
        check("pulse_rdy_mask",  32'(rmask), 32'(0));
        check("pulse_done_mask", 32'(dmask), 32'(10'b0000000001));
        check("pulse_id",        32'(a_done_id), 32'(1));
        check("pulse_count",     32'(a_done_count), 32'(2));
        late_done = 0; late_rdy = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #2;
            late_done += int'(a_done);
            late_rdy  += int'(a_req0_ready | a_req1_ready);
        end
        check("pulse_extra_done",  32'(late_done), 32'(0));
        check("pulse_extra_ready", 32'(late_rdy),  32'(0));

        // PATTERN=1111 instance: ans over T+5..T+9, count saturates at 5
        job("ones", 1, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 10'b0000111110, 4'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pattern_stream_sched.md
# pattern_stream_sched

Two-requester round-robin scheduler in front of a serial Moore pattern detector. The block accepts a byte from either requester through a valid/ready handshake and shifts its bits MSB-first into the detector. It counts the detector's (overlapping) matches within that byte and reports the count with the requester id. It is the sequencing layer that lets several byte producers share one bit-serial Moore detector datapath.

## Interface
- DATA_W, 8, bits per job (counter widths below assume 8)
- PAT_LEN, 4, pattern length in bits
- PATTERN, 4'b1011, pattern matched; first-received bit is PATTERN[PAT_LEN-1]
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a byte
- req0_data  in  8  requester 0 byte; held stable while valid and not ready
- req0_ready  out  1  requester 0 byte accepted this cycle
- req1_valid / req1_data / req1_ready: same as requester 0, for requester 1
- inbit  out  1  serial bit currently driven into the detector
- ans  out  1  Moore detector output: last PAT_LEN shifted bits of the current job equal PATTERN
- busy  out  1  job in progress (state not IDLE)
- done  out  1  one-cycle pulse, result valid
- done_id  out  1  requester that owned the finished job
- done_count  out  4  matches found in the job (0..5)

## Operation
- FSM: IDLE -> SHIFT -> FLUSH -> DONE -> IDLE.
- IDLE:
  - Arbitrate; reqN_ready = (state==IDLE) & grant==N & reqN_valid (combinational).
  - Grant rule: one valid -> that one. Both valid -> the one not granted last. last_grant resets to 1, so req0 wins the first tie.
  - On handshake: load the shift register with the data, record id, update last_grant, clear bit counter, detector history and match count, go to SHIFT.
- SHIFT, exactly DATA_W cycles:
  - inbit = shreg MSB; shift left each edge.
  - Detector history shifts in inbit; seen-count saturates at PAT_LEN.
  - After the 8th bit, go to FLUSH.
- Detector (Moore): ans = (history==PATTERN) & (seen>=PAT_LEN), from registers only. Matches overlap. History is cleared at every job start, so there are no cross-byte matches.
- Counting: on every edge while in SHIFT or FLUSH with ans=1, increment match count (max 5, no overflow).
- FLUSH: one cycle, so the final bit's ans is observed and counted. inbit=0. Go to DONE.
- DONE:
  - done=1; done_id and done_count hold the job result. They are held until the next job's DONE; only done pulses.
  - Return to IDLE.
- Requester valid is ignored outside IDLE. A valid that drops before ready is never accepted.
- Reset, including mid-job:
  - All state is cleared immediately. FSM=IDLE, last_grant=1.
  - All outputs go to 0: ready, inbit, ans, busy, done, done_id, done_count.
  - The in-flight job is dropped; no done is produced.

## Timing
- Handshake in cycle T (ready=1 at edge end of T).
- SHIFT occupies cycles T+1..T+8; bit k (k=1..8, MSB first) is on inbit in cycle T+k.
- ans reflects bits up to k in cycle T+k+1.
- FLUSH is cycle T+9; DONE (done=1) is cycle T+10.
- IDLE is cycle T+11, which is the earliest next ready.
- Throughput: one job per 11 cycles. busy=1 over T+1..T+10.
- ready is never asserted to both requesters in the same cycle.

## Test plan
- Reset, then req0 0xB6 alone:
  - ready at T.
  - inbit sequence 1,0,1,1,0,1,1,0 over T+1..T+8.
  - ans=1 only in T+5 and T+8.
  - done at T+10 with id=0, count=2.
- Both valid from reset, req0 0x00 and req1 0xBB:
  - req0 granted first, count=0.
  - req1 granted at the following IDLE (T+11), count=2.
  - Held-valid requesters then alternate 0,1,0,1.
- PATTERN 1011, req1 0x5B: count=2. req1 0xB5: count=1. No match carries across back-to-back jobs 0x01 then 0x60.
- Instance with PATTERN=4'b1111, byte 0xFF: ans high in cycles T+5..T+9, done_count=5.
- rst_n low at T+4 of a job: outputs 0 asynchronously, no done pulse. After release, req0 wins the tie.
- req0_valid pulsed only during SHIFT: never accepted, no ready, no extra done.
